qspi_mem_responder: RTL

- QSPI target that sits at the far end of the SoC memory bus, facing the initiator's CS/SCK/SD[3:0] pins, and serves a byte-wide memory port.
- Used as the on-chip/FPGA stand-in for the external QSPI ROM/RAM, and as a synthesizable bench model.
- Oversamples SCK with the single system clock (clk_i ≥ 4× SCK); no SCK-domain logic.

---
 rtl/qspi_mem_responder.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/qspi_mem_responder.sv
// Quad-SPI memory target. CS/SCK/SD are oversampled by clk_i and serve a byte-wide memory port.
// Define QSPI_RESP_WPROT_EN to block writes below WP_LIMIT.
module qspi_mem_responder #(
    parameter int          AW       = 24,
    parameter int          DUMMY    = 4,
    parameter logic [23:0] WP_LIMIT = 24'h000400
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cs_n_i,
    input  logic          sck_i,
    input  logic [3:0]    sd_i,
    output logic [3:0]    sd_o,
    output logic [3:0]    sd_oen_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_wdata_o,
    input  logic [7:0]    mem_rdata_i,
    input  logic          mem_ack_i,
    output logic          err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
    } state_t;

    localparam logic [7:0] CMD_READ   = 8'hEB;
    localparam logic [7:0] CMD_WRITE  = 8'h38;
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY - 1);

    state_t        r_state;
    logic          r_cs_meta, r_cs_sync;
    logic          r_sck_meta, r_sck_sync, r_sck_prev;
    logic [3:0]    r_sd_meta, r_sd_sync;
    logic [19:0]   r_shift;
    logic [7:0]    r_cnt;
    logic          r_half;
    logic          r_is_read;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_mem_addr;
    logic          r_req, r_we;
    logic [7:0]    r_wdata;
    logic [7:0]    r_rbyte;
    logic          r_rvalid;
    logic          r_bad;
    logic          r_fetch_pend;
    logic          r_rd_skip;
    logic [3:0]    r_sd_out, r_oen;
    logic          r_err;

    logic          w_sck_rise, w_sck_fall;
    logic [7:0]    w_byte;
    logic          w_protected;

    assign w_sck_rise = r_sck_sync & ~r_sck_prev;
    assign w_sck_fall = ~r_sck_sync & r_sck_prev;
    assign w_byte     = {r_shift[3:0], r_sd_sync};

`ifdef QSPI_RESP_WPROT_EN
    assign w_protected = (24'(r_addr) < WP_LIMIT);
`else
    logic w_unused_wp;
    assign w_unused_wp = ^WP_LIMIT;
    assign w_protected = 1'b0;
`endif

    assign sd_o        = r_sd_out;
    assign sd_oen_o    = r_oen;
    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_wdata;
    assign err_o       = r_err;

    // NOTE: non-blocking throughout; a later assignment in this block deliberately
    // overrides an earlier one (CS abort and byte consumption win over ack capture).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_cs_meta    <= 1'b1;
            r_cs_sync    <= 1'b1;
            r_sck_meta   <= 1'b0;
            r_sck_sync   <= 1'b0;
            r_sck_prev   <= 1'b0;
            r_sd_meta    <= 4'h0;
            r_sd_sync    <= 4'h0;
            r_shift      <= 20'h0;
            r_cnt        <= 8'h0;
            r_half       <= 1'b0;
            r_is_read    <= 1'b0;
            r_addr       <= '0;
            r_mem_addr   <= '0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_wdata      <= 8'h0;
            r_rbyte      <= 8'h0;
            r_rvalid     <= 1'b0;
            r_bad        <= 1'b0;
            r_fetch_pend <= 1'b0;
            r_rd_skip    <= 1'b0;
            r_sd_out     <= 4'h0;
            r_oen        <= 4'h0;
            r_err        <= 1'b0;
        end else begin
            r_cs_meta  <= cs_n_i;
            r_cs_sync  <= r_cs_meta;
            r_sck_meta <= sck_i;
            r_sck_sync <= r_sck_meta;
            r_sck_prev <= r_sck_sync;
            r_sd_meta  <= sd_i;
            r_sd_sync  <= r_sd_meta;
            if (w_sck_rise)
                r_shift <= {r_shift[15:0], r_sd_sync};

            // Memory handshake; read prefetches go out as soon as the bus is free.
            if (r_req && mem_ack_i) begin
                r_req <= 1'b0;
                if (!r_we) begin
                    if (r_rd_skip) begin
                        r_rd_skip <= 1'b0;
                    end else begin
                        r_rbyte  <= mem_rdata_i;
                        r_rvalid <= 1'b1;
                    end
                end
            end else if (r_fetch_pend && !r_req && !r_cs_sync) begin
                r_req        <= 1'b1;
                r_we         <= 1'b0;
                r_mem_addr   <= r_addr;
                r_addr       <= r_addr + 1'b1;
                r_fetch_pend <= 1'b0;
            end

            if (r_cs_sync) begin
                r_state      <= S_IDLE;
                r_oen        <= 4'h0;
                r_sd_out     <= 4'h0;
                r_cnt        <= 8'h0;
                r_half       <= 1'b0;
                r_rvalid     <= 1'b0;
                r_bad        <= 1'b0;
                r_fetch_pend <= 1'b0;
                if (r_req && !r_we && !mem_ack_i)
                    r_rd_skip <= 1'b1;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_state <= S_CMD;
                        r_cnt   <= 8'h0;
                    end
                    S_CMD: if (w_sck_rise) begin
                        if (r_cnt == 8'd1) begin
                            r_cnt <= 8'h0;
                            case (w_byte)
                                CMD_READ: begin
                                    r_is_read <= 1'b1;
                                    r_state   <= S_ADDR;
                                end
                                CMD_WRITE: begin
                                    r_is_read <= 1'b0;
                                    r_state   <= S_ADDR;
                                end
                                default: r_state <= S_IGNORE;
                            endcase
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    S_ADDR: if (w_sck_rise) begin
                        if (r_cnt == 8'd5) begin
                            r_cnt  <= 8'h0;
                            r_half <= 1'b0;
                            r_addr <= AW'({r_shift, r_sd_sync});
                            if (r_is_read) begin
                                r_fetch_pend <= 1'b1;
                                r_rvalid     <= 1'b0;
                                r_bad        <= 1'b0;
                                r_state      <= S_DUMMY;
                            end else begin
                                r_state <= S_WDATA;
                            end
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    S_DUMMY: if (w_sck_rise) begin
                        if (r_cnt == DUMMY_LAST) begin
                            r_cnt   <= 8'h0;
                            r_oen   <= 4'hF;
                            r_state <= S_RDATA;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    S_RDATA: if (w_sck_fall) begin
                        if (!r_half) begin
                            r_half <= 1'b1;
                            if (r_rvalid) begin
                                r_sd_out <= r_rbyte[7:4];
                            end else begin
                                r_sd_out <= 4'h0;
                                r_err    <= 1'b1;
                                r_bad    <= 1'b1;
                            end
                        end else begin
                            // Byte consumed: request the next one; a late ack for this byte is dropped.
                            r_half       <= 1'b0;
                            r_sd_out     <= r_bad ? 4'h0 : r_rbyte[3:0];
                            r_bad        <= 1'b0;
                            r_rvalid     <= 1'b0;
                            r_fetch_pend <= 1'b1;
                            if (r_req && !mem_ack_i)
                                r_rd_skip <= 1'b1;
                        end
                    end
                    S_WDATA: if (w_sck_rise) begin
                        if (!r_half) begin
                            r_half <= 1'b1;
                        end else begin
                            r_half <= 1'b0;
                            r_addr <= r_addr + 1'b1;
                            if (!w_protected) begin
                                if (r_req) begin
                                    r_err <= 1'b1;
                                end else begin
                                    r_req      <= 1'b1;
                                    r_we       <= 1'b1;
                                    r_mem_addr <= r_addr;
                                    r_wdata    <= w_byte;
                                end
                            end
                        end
                    end
                    S_IGNORE: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
